// File: rtl/secded_pkg.sv
// rtl/secded_pkg.sv - SECDED code geometry helpers and status type shared by decoder/encoder blocks
package secded_pkg;

  typedef enum logic [1:0] {
    SECDED_OK     = 2'd0,
    SECDED_SINGLE = 2'd1,
    SECDED_DOUBLE = 2'd2
  } secded_status_e;

  // Smallest P with 2^P >= data_w + P + 1 (Hamming parity bit count).
  function automatic int secded_par_bits(input int data_w);
    int p;
    p = 1;
    for (int i = 0; i < 8; i++) begin
      if ((1 << p) < data_w + p + 1) p = p + 1;
    end
    return p;
  endfunction

  // Full code width: data + Hamming parity + one global parity bit.
  function automatic int secded_code_w(input int data_w);
    return data_w + secded_par_bits(data_w) + 1;
  endfunction

  // Code bit index of data bit i: data fills non-power-of-two Hamming
  // positions in ascending order, and code bit k carries position k+1.
  function automatic int secded_data_pos(input int i);
    int cnt;
    int idx;
    cnt = 0;
    idx = 0;
    for (int pos = 3; pos < 128; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        if (cnt == i) idx = pos - 1;
        cnt = cnt + 1;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/secded_syndrome.sv
// rtl/secded_syndrome.sv - combinational Hamming syndrome and global parity of a SECDED code word
module secded_syndrome import secded_pkg::*; #(
  parameter int DATA_W = 4
) (
  input  logic [secded_code_w(DATA_W)-1:0]   code_i,
  output logic [secded_par_bits(DATA_W)-1:0] syndrome_o,
  output logic                               gpar_o
);

  localparam int P = secded_par_bits(DATA_W);
  localparam int N = secded_code_w(DATA_W);

  // Syndrome is the XOR of the Hamming positions of every set bit; the
  // global-parity bit (index N-1) has no Hamming position and is excluded.
  always_comb begin
    syndrome_o = '0;
    for (int k = 0; k < N - 1; k++) begin
      if (code_i[k]) syndrome_o = syndrome_o ^ P'(k + 1);
    end
  end

  // Even parity over the whole word: 1 means an odd number of flipped bits.
  assign gpar_o = ^code_i;

endmodule

// File: rtl/secded_dec_pipe.sv
// rtl/secded_dec_pipe.sv - two-stage SECDED decoder with valid/ready stream; SECDED_STATS_EN adds error counters
module secded_dec_pipe import secded_pkg::*; #(
  parameter int DATA_W = 4,
  parameter int CNT_W  = 16
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [secded_code_w(DATA_W)-1:0]   in_code,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [DATA_W-1:0]                  out_data,
  output logic                               out_single,
  output logic                               out_double,
  output logic [secded_par_bits(DATA_W)-1:0] out_syndrome
`ifdef SECDED_STATS_EN
  ,
  input  logic                               cnt_clr,
  output logic [CNT_W-1:0]                   cnt_single,
  output logic [CNT_W-1:0]                   cnt_double
`endif
);

  localparam int P = secded_par_bits(DATA_W);
  localparam int N = secded_code_w(DATA_W);

  if (DATA_W < 4 || DATA_W > 64 || CNT_W < 1) begin : g_param_err
    $error("secded_dec_pipe: DATA_W must be 4..64 and CNT_W >= 1");
  end

  logic [P-1:0] syn_d;
  logic         gpar_d;

  secded_syndrome #(.DATA_W(DATA_W)) u_syndrome (
    .code_i     (in_code),
    .syndrome_o (syn_d),
    .gpar_o     (gpar_d)
  );

  logic               s1_valid_q;
  logic [N-1:0]       s1_code_q;
  logic [P-1:0]       s1_syn_q;
  logic               s1_gpar_q;
  logic               s2_valid_q;
  logic [DATA_W-1:0]  s2_data_q;
  logic               s2_single_q;
  logic               s2_double_q;
  logic [P-1:0]       s2_syn_q;
  logic               s1_load;
  logic               s2_load;

  // Stage 2 refills when empty or draining; stage 1 refills when empty or
  // moving into stage 2, so a full pipe streams one word per cycle.
  assign s2_load  = !s2_valid_q || out_ready;
  assign s1_load  = !s1_valid_q || s2_load;
  assign in_ready = s1_load;

  // Stage 1 register: raw code plus its syndrome and global parity.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_code_q  <= '0;
      s1_syn_q   <= '0;
      s1_gpar_q  <= 1'b0;
    end else if (s1_load) begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        s1_code_q <= in_code;
        s1_syn_q  <= syn_d;
        s1_gpar_q <= gpar_d;
      end
    end
  end

  secded_status_e    status_d;
  logic [N-1:0]      corr_code_d;
  logic [DATA_W-1:0] data_d;

  // Classify the word and correct the single flipped bit when its position
  // is a real code position; double errors pass through uncorrected.
  always_comb begin
    status_d    = SECDED_OK;
    corr_code_d = s1_code_q;
    if (s1_syn_q == '0) begin
      status_d = s1_gpar_q ? SECDED_SINGLE : SECDED_OK;
    end else if (!s1_gpar_q) begin
      status_d = SECDED_DOUBLE;
    end else if (int'(s1_syn_q) > N - 1) begin
      status_d = SECDED_DOUBLE;
    end else begin
      status_d = SECDED_SINGLE;
      for (int k = 0; k < N - 1; k++) begin
        if (s1_syn_q == P'(k + 1)) corr_code_d[k] = ~s1_code_q[k];
      end
    end
  end

  for (genvar gi = 0; gi < DATA_W; gi++) begin : g_extract
    assign data_d[gi] = corr_code_d[secded_data_pos(gi)];
  end

  // Parity positions of the corrected word are not needed downstream.
  logic unused_code_bits;
  assign unused_code_bits = ^corr_code_d;

  // Stage 2 register: corrected data and status, held while back-pressured.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_q  <= 1'b0;
      s2_data_q   <= '0;
      s2_single_q <= 1'b0;
      s2_double_q <= 1'b0;
      s2_syn_q    <= '0;
    end else if (s2_load) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        s2_data_q   <= data_d;
        s2_single_q <= (status_d == SECDED_SINGLE);
        s2_double_q <= (status_d == SECDED_DOUBLE);
        s2_syn_q    <= s1_syn_q;
      end
    end
  end

  assign out_valid    = s2_valid_q;
  assign out_data     = s2_data_q;
  assign out_single   = s2_single_q;
  assign out_double   = s2_double_q;
  assign out_syndrome = s2_syn_q;

`ifdef SECDED_STATS_EN
  logic             out_xfer;
  logic [CNT_W-1:0] cnt_single_q;
  logic [CNT_W-1:0] cnt_single_d;
  logic [CNT_W-1:0] cnt_double_q;
  logic [CNT_W-1:0] cnt_double_d;

  assign out_xfer = s2_valid_q && out_ready;

  // Saturating counters bumped on each delivered word; clear has priority.
  always_comb begin
    cnt_single_d = cnt_single_q;
    cnt_double_d = cnt_double_q;
    if (cnt_clr) begin
      cnt_single_d = '0;
      cnt_double_d = '0;
    end else if (out_xfer) begin
      if (s2_single_q && !(&cnt_single_q)) cnt_single_d = cnt_single_q + 1'b1;
      if (s2_double_q && !(&cnt_double_q)) cnt_double_d = cnt_double_q + 1'b1;
    end
  end

  // Counter state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_single_q <= '0;
      cnt_double_q <= '0;
    end else begin
      cnt_single_q <= cnt_single_d;
      cnt_double_q <= cnt_double_d;
    end
  end

  assign cnt_single = cnt_single_q;
  assign cnt_double = cnt_double_q;
`endif

endmodule

// File: tb/tb_secded_dec_pipe.sv
// tb/tb_secded_dec_pipe.sv - self-checking bench for secded_dec_pipe (DATA_W=4), optional SECDED_STATS_EN checks
module tb_secded_dec_pipe;

  localparam int DATA_W = 4;
  localparam int P      = 3;
  localparam int N      = 8;
`ifdef SECDED_STATS_EN
  localparam int CNT_W  = 2;
`else
  localparam int CNT_W  = 16;
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [N-1:0]      in_code = '0;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [DATA_W-1:0] out_data;
  logic              out_single;
  logic              out_double;
  logic [P-1:0]      out_syndrome;
`ifdef SECDED_STATS_EN
  logic              cnt_clr = 1'b0;
  logic [CNT_W-1:0]  cnt_single;
  logic [CNT_W-1:0]  cnt_double;
`endif

  secded_dec_pipe #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_code      (in_code),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_single   (out_single),
    .out_double   (out_double),
    .out_syndrome (out_syndrome)
`ifdef SECDED_STATS_EN
    ,
    .cnt_clr      (cnt_clr),
    .cnt_single   (cnt_single),
    .cnt_double   (cnt_double)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              single;
    logic              dbl;
    logic [P-1:0]      syn;
  } res_t;

  res_t              exp_q[$];
  res_t              pend_exp;
  res_t              hold_val;
  logic              hold_pend = 1'b0;
  logic              last_in_xfer = 1'b0;
  logic              last_in_ready = 1'b0;
  logic              last_out_valid = 1'b0;
  logic [DATA_W-1:0] last_out_data = '0;
  int                n_asserts = 0;
  int                n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic res_t mk(input logic [DATA_W-1:0] d, input logic s, input logic db,
                              input logic [P-1:0] syn);
    res_t r;
    r.data = d; r.single = s; r.dbl = db; r.syn = syn;
    return r;
  endfunction

  function automatic res_t cur_res();
    return {out_data, out_single, out_double, out_syndrome};
  endfunction

  // Model: code bit index of data bit i (non-power-of-two positions, ascending).
  function automatic int data_pos(input int i);
    int cnt;
    int r;
    cnt = 0; r = 0;
    for (int pos = 1; pos < N; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        if (cnt == i) r = pos - 1;
        cnt++;
      end
    end
    return r;
  endfunction

  // Model encoder: place data, fill each parity bit, then even global parity.
  function automatic logic [N-1:0] encode(input logic [DATA_W-1:0] d);
    logic [N-1:0] c;
    logic b;
    c = '0;
    for (int i = 0; i < DATA_W; i++) c[data_pos(i)] = d[i];
    for (int j = 0; j < P; j++) begin
      b = 1'b0;
      for (int pos = 1; pos < N; pos++) if (((pos >> j) & 1) == 1) b = b ^ c[pos-1];
      c[(1 << j) - 1] = b;
    end
    c[N-1] = ^c[N-2:0];
    return c;
  endfunction

  // Model decoder outcome from the injected error pattern (code is linear, so
  // the syndrome is that of the error pattern alone).
  function automatic res_t model(input logic [DATA_W-1:0] d, input logic [N-1:0] err);
    res_t r;
    int syn;
    int nerr;
    syn = 0;
    nerr = $countones(err);
    for (int k = 0; k < N - 1; k++) if (err[k]) syn = syn ^ (k + 1);
    r.data = d;
    if (nerr == 2) for (int i = 0; i < DATA_W; i++) if (err[data_pos(i)]) r.data[i] = ~d[i];
    r.single = (nerr == 1);
    r.dbl    = (nerr == 2);
    r.syn    = syn[P-1:0];
    return r;
  endfunction

  // One clock: sample at the falling edge, score transfers, advance past the rising edge.
  task automatic step();
    res_t e;
    @(negedge clk);
    if (hold_pend) begin
      chk("hold_valid", 32'(out_valid), 1);
      chk("hold_word", 32'(cur_res()), 32'(hold_val));
    end
    hold_pend      = out_valid && !out_ready;
    hold_val       = cur_res();
    last_in_ready  = in_ready;
    last_out_valid = out_valid;
    last_out_data  = out_data;
    last_in_xfer   = in_valid && in_ready;
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) chk("spurious_out_valid", 32'(out_valid), 0);
      else begin
        e = exp_q.pop_front();
        chk("out_word", 32'(cur_res()), 32'(e));
      end
    end
    if (last_in_xfer) exp_q.push_back(pend_exp);
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [N-1:0] code, input res_t e, input bit rand_ready);
    in_valid = 1'b1; in_code = code; pend_exp = e;
    for (int t = 0; t < 50; t++) begin
      if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
      step();
      if (last_in_xfer) break;
    end
    if (!last_in_xfer) chk("send_timeout", 32'(last_in_ready), 1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int t = 0; t < 50 && exp_q.size() != 0; t++) step();
    chk("drain_empty", 32'(exp_q.size()), 0);
    step();
    step();
  endtask

  initial begin
    logic [DATA_W-1:0] d;
    logic [N-1:0]      err;
    int                nerr;
    int                k1;
    int                k2;

    // Reset state
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_word", 32'(cur_res()), 0);
`ifdef SECDED_STATS_EN
    chk("rst_cnt_single", 32'(cnt_single), 0);
    chk("rst_cnt_double", 32'(cnt_double), 0);
`endif
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 1);
    @(posedge clk);
    #1;

    // Clean word and two-cycle latency
    in_valid = 1'b1; in_code = 8'h55; pend_exp = mk(4'hB, 1'b0, 1'b0, 3'd0);
    step();
    chk("lat_xfer", 32'(last_in_xfer), 1);
    in_valid = 1'b0;
    @(negedge clk);
    chk("lat_cycle1_valid", 32'(out_valid), 0);
    @(posedge clk);
    #1;
    step();
    chk("lat_cycle2_valid", 32'(last_out_valid), 1);
    drain();

    // Single, global-parity and double errors, streamed back to back
    send(8'h45, mk(4'hB, 1'b1, 1'b0, 3'd5), 1'b0);
    chk("stream_in_ready0", 32'(last_in_ready), 1);
    send(8'hD5, mk(4'hB, 1'b1, 1'b0, 3'd0), 1'b0);
    chk("stream_in_ready1", 32'(last_in_ready), 1);
    send(8'h56, mk(4'hB, 1'b0, 1'b1, 3'd3), 1'b0);
    chk("stream_in_ready2", 32'(last_in_ready), 1);
    drain();

    // Back-pressure with both stages full
    out_ready = 1'b0;
    send(8'h00, mk(4'h0, 1'b0, 1'b0, 3'd0), 1'b0);
    send(8'h55, mk(4'hB, 1'b0, 1'b0, 3'd0), 1'b0);
    in_valid = 1'b1; in_code = 8'h45; pend_exp = mk(4'hB, 1'b1, 1'b0, 3'd5);
    for (int c = 0; c < 5; c++) begin
      step();
      chk("bp_in_ready", 32'(last_in_ready), 0);
      chk("bp_out_data", 32'(last_out_data), 0);
    end
    out_ready = 1'b1;
    send(8'h45, mk(4'hB, 1'b1, 1'b0, 3'd5), 1'b0);
    drain();

    // Mid-stream reset discards in-flight words
    out_ready = 1'b0;
    send(8'h55, mk(4'hB, 1'b0, 1'b0, 3'd0), 1'b0);
    send(8'h45, mk(4'hB, 1'b1, 1'b0, 3'd5), 1'b0);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 0);
    exp_q.delete();
    hold_pend = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (4) step();
    chk("midrst_idle", 32'(last_out_valid), 0);

    // Randomized words with 0, 1 or 2 bit errors under random back-pressure
    for (int w = 0; w < 80; w++) begin
      d    = DATA_W'($urandom);
      nerr = int'($urandom_range(0, 2));
      k1   = int'($urandom_range(0, N - 1));
      k2   = (k1 + int'($urandom_range(1, N - 1))) % N;
      err  = '0;
      if (nerr >= 1) err[k1] = 1'b1;
      if (nerr == 2) err[k2] = 1'b1;
      if ($urandom_range(0, 3) == 0) begin
        out_ready = ($urandom_range(0, 1) != 0);
        step();
      end
      send(encode(d) ^ err, model(d, err), 1'b1);
    end
    drain();

`ifdef SECDED_STATS_EN
    // Saturation and clear priority
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    chk("cnt_clr_single", 32'(cnt_single), 0);
    chk("cnt_clr_double", 32'(cnt_double), 0);
    for (int i = 0; i < 4; i++) send(8'h45, mk(4'hB, 1'b1, 1'b0, 3'd5), 1'b0);
    drain();
    chk("cnt_sat_single", 32'(cnt_single), 3);
    chk("cnt_sat_double", 32'(cnt_double), 0);
    send(8'h56, mk(4'hB, 1'b0, 1'b1, 3'd3), 1'b0);
    drain();
    chk("cnt_double_one", 32'(cnt_double), 1);
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    out_ready = 1'b0;
    send(8'h45, mk(4'hB, 1'b1, 1'b0, 3'd5), 1'b0);
    step();
    chk("cc_out_valid", 32'(out_valid), 1);
    cnt_clr = 1'b1;
    out_ready = 1'b1;
    step();
    cnt_clr = 1'b0;
    chk("cc_cnt_single", 32'(cnt_single), 0);
    drain();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout asserts=%0d failures=%0d", n_asserts, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
